sdram_chan_arbiter: RTL and testbench

//  Shares one SDRAM controller channel between NREQ read-only video fetchers and the ROM loader write port.

---
 rtl/sdram_chan_arbiter.sv | 150 +++++++++++++++
 tb/tb_sdram_chan_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_chan_arbiter.sv
// Shares one SDRAM channel between NREQ round-robin read fetchers and a ROM loader write port.
// A transaction the channel never acknowledges is re-issued unchanged after TMO cycles.
module sdram_chan_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 25,
  parameter int DW   = 16,
  parameter int TMO  = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rom_mode,
  input  logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_din,
  input  logic [1:0]         rom_be,
  input  logic               rom_req,
  output logic               rom_rdy,
  input  logic [NREQ-1:0]    rd_req,
  input  logic [NREQ*AW-1:0] rd_addr,
  output logic [DW-1:0]      rd_data,
  output logic [NREQ-1:0]    rd_rdy,
  output logic [AW-1:0]      sdr_addr,
  output logic [DW-1:0]      sdr_din,
  output logic [1:0]         sdr_be,
  output logic               sdr_rnw,
  output logic               sdr_req,
  input  logic               sdr_rdy,
  input  logic [DW-1:0]      sdr_dout,
  output logic               tmo_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RETRY} state_t;

  state_t        state, state_d;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic          owner_rom;
  logic [7:0]    timer;

  logic          grant_rd, grant_rom, done, tmo_hit;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] j;

  always_comb begin
    state_d   = state;
    grant_rd  = 1'b0;
    grant_rom = 1'b0;
    grant_idx = '0;
    done      = 1'b0;
    tmo_hit   = 1'b0;
    j         = '0;
    case (state)
      IDLE: begin
        if (rom_mode) begin
          if (rom_req) begin
            grant_rom = 1'b1;
            state_d   = BUSY;
          end
        end else begin
          // First requester at or after rr_ptr, wrapping past NREQ-1.
          for (int k = 0; k < NREQ; k++) begin
            j = PW'((int'(rr_ptr) + k) % NREQ);
            if (!grant_rd && rd_req[j]) begin
              grant_rd  = 1'b1;
              grant_idx = j;
            end
          end
          if (grant_rd) state_d = BUSY;
        end
      end
      BUSY: begin
        if (sdr_rdy) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (timer == 8'(TMO)) begin
          tmo_hit = 1'b1;
          state_d = RETRY;
        end
      end
      RETRY:   state_d = BUSY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      owner_rom <= 1'b0;
      timer     <= '0;
      sdr_req   <= 1'b0;
      sdr_rnw   <= 1'b1;
      sdr_be    <= 2'b11;
      sdr_addr  <= '0;
      sdr_din   <= '0;
      rd_rdy    <= '0;
      rom_rdy   <= 1'b0;
      rd_data   <= '0;
      tmo_err   <= 1'b0;
    end else begin
      state   <= state_d;
      rd_rdy  <= '0;
      rom_rdy <= 1'b0;

      // Grant: latch the transaction; it stays fixed across retries.
      if (grant_rom) begin
        sdr_addr  <= rom_addr;
        sdr_din   <= rom_din;
        sdr_be    <= rom_be;
        sdr_rnw   <= 1'b0;
        owner_rom <= 1'b1;
        sdr_req   <= 1'b1;
        timer     <= '0;
      end else if (grant_rd) begin
        sdr_addr  <= rd_addr[int'(grant_idx)*AW +: AW];
        sdr_be    <= 2'b11;
        sdr_rnw   <= 1'b1;
        owner_rom <= 1'b0;
        owner     <= grant_idx;
        sdr_req   <= 1'b1;
        timer     <= '0;
      end

      // Completion / timeout while the channel owns the request.
      if (done) begin
        sdr_req <= 1'b0;
        timer   <= '0;
        if (owner_rom) begin
          rom_rdy <= 1'b1;
        end else begin
          rd_rdy[owner] <= 1'b1;
          rd_data       <= sdr_dout;
          if (int'(owner) == NREQ - 1) rr_ptr <= '0;
          else                         rr_ptr <= owner + 1'b1;
        end
      end else if (tmo_hit) begin
        sdr_req <= 1'b0;
        tmo_err <= 1'b1;
        timer   <= '0;
      end else if (state == BUSY) begin
        timer <= timer + 8'd1;
      end

      if (state == RETRY) sdr_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_chan_arbiter.sv
// Directed bench for sdram_chan_arbiter: behavioural channel responder, bus monitor
// and one task per scenario with inline expected-value comparisons.
module tb_sdram_chan_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 25;
  localparam int DW   = 16;
  localparam int TMO  = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               rom_mode;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_din;
  logic [1:0]         rom_be;
  logic               rom_req;
  logic               rom_rdy;
  logic [NREQ-1:0]    rd_req;
  logic [NREQ*AW-1:0] rd_addr;
  logic [DW-1:0]      rd_data;
  logic [NREQ-1:0]    rd_rdy;
  logic [AW-1:0]      sdr_addr;
  logic [DW-1:0]      sdr_din;
  logic [1:0]         sdr_be;
  logic               sdr_rnw;
  logic               sdr_req;
  logic               sdr_rdy;
  logic [DW-1:0]      sdr_dout;
  logic               tmo_err;

  int checks = 0;
  int failures = 0;

  sdram_chan_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .rom_mode(rom_mode), .rom_addr(rom_addr), .rom_din(rom_din), .rom_be(rom_be),
    .rom_req(rom_req), .rom_rdy(rom_rdy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_rdy(rd_rdy),
    .sdr_addr(sdr_addr), .sdr_din(sdr_din), .sdr_be(sdr_be), .sdr_rnw(sdr_rnw),
    .sdr_req(sdr_req), .sdr_rdy(sdr_rdy), .sdr_dout(sdr_dout), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  // Channel model: answers lat cycles after seeing sdr_req, data fixed or derived from address.
  logic          chan_en = 1'b0;
  int            lat = 2;
  logic          fixed_data = 1'b0;
  logic [DW-1:0] resp_data = '0;
  logic          auto_rdy = 1'b0;
  logic [DW-1:0] auto_dout = '0;
  logic          man_rdy = 1'b0;
  int            cnt = 0;

  assign sdr_rdy  = auto_rdy | man_rdy;
  assign sdr_dout = auto_dout;

  always @(negedge clk) begin
    if (!chan_en || !sdr_req || auto_rdy) begin
      auto_rdy = 1'b0;
      cnt = 0;
    end else if (cnt >= lat) begin
      auto_rdy  = 1'b1;
      auto_dout = fixed_data ? resp_data : (sdr_addr[15:0] ^ 16'h5A5A);
    end else begin
      cnt++;
    end
  end

  // Monitor: logs each issued transaction, high/low durations of sdr_req and ready pulses.
  logic [AW-1:0] g_addr[$];
  logic          g_rnw[$];
  logic [1:0]    g_be[$];
  logic [DW-1:0] g_din[$];
  int            g_gap[$];
  int            g_hi[$];
  int            rd_pulses = 0;
  int            rom_pulses = 0;
  int            multi_hot = 0;
  logic          prev_req = 1'b0;
  int            hic = 0;
  int            lowc = 0;

  always @(negedge clk) begin
    if (sdr_req) begin
      if (!prev_req) begin
        g_addr.push_back(sdr_addr);
        g_rnw.push_back(sdr_rnw);
        g_be.push_back(sdr_be);
        g_din.push_back(sdr_din);
        g_gap.push_back(lowc);
        hic = 1;
      end else begin
        hic++;
      end
    end else begin
      if (prev_req) begin
        g_hi.push_back(hic);
        lowc = 1;
      end else begin
        lowc++;
      end
    end
    prev_req = sdr_req;
    if (rd_rdy != '0) rd_pulses++;
    if ($countones(rd_rdy) > 1) multi_hot++;
    if (rom_rdy) rom_pulses++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int budget, output logic [NREQ-1:0] rr,
                            output logic rm, output logic ok);
    ok = 1'b0; rr = '0; rm = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rd_rdy != '0 || rom_rdy) begin
        rr = rd_rdy; rm = rom_rdy; ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rom_mode = 1'b0; rom_addr = '0; rom_din = '0; rom_be = '0; rom_req = 1'b0;
    rd_req = '0; rd_addr = '0;
    cycles(3);
    checks++; if (sdr_req !== 1'b0) begin failures++; $display("FAIL reset_sdr_req got=%b exp=0", sdr_req); end
    checks++; if (sdr_rnw !== 1'b1) begin failures++; $display("FAIL reset_sdr_rnw got=%b exp=1", sdr_rnw); end
    checks++; if (sdr_be !== 2'b11) begin failures++; $display("FAIL reset_sdr_be got=%b exp=11", sdr_be); end
    checks++; if (sdr_addr !== '0) begin failures++; $display("FAIL reset_sdr_addr got=%h exp=0", sdr_addr); end
    checks++; if (sdr_din !== '0) begin failures++; $display("FAIL reset_sdr_din got=%h exp=0", sdr_din); end
    checks++; if (rd_rdy !== '0 || rom_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b/%b exp=000/0", rd_rdy, rom_rdy); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    checks++; if (tmo_err !== 1'b0) begin failures++; $display("FAIL reset_tmo_err got=%b exp=0", tmo_err); end
    reset = 1'b0;
    cycles(1);
  endtask

  task automatic test_single();
    logic [NREQ-1:0] rr; logic rm, ok; int base;
    base = g_addr.size();
    chan_en = 1'b1; lat = 4; fixed_data = 1'b1; resp_data = 16'hBEEF;
    rd_addr[1*AW +: AW] = 25'h000100;
    rd_req = 3'b010;
    wait_pulse(50, rr, rm, ok);
    rd_req = '0;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_timeout got=none exp=pulse"); end
    checks++; if (rr !== 3'b010) begin failures++; $display("FAIL single_rd_rdy got=%b exp=010", rr); end
    checks++; if (rd_data !== 16'hBEEF) begin failures++; $display("FAIL single_rd_data got=%h exp=beef", rd_data); end
    cycles(5);
    checks++; if (g_addr.size() - base !== 1) begin failures++; $display("FAIL single_grants got=%0d exp=1", g_addr.size() - base); end
    if (g_addr.size() > base) begin
      checks++; if (g_addr[base] !== 25'h000100 || g_rnw[base] !== 1'b1 || g_be[base] !== 2'b11) begin
        failures++; $display("FAIL single_bus got=%h/%b/%b exp=000100/1/11", g_addr[base], g_rnw[base], g_be[base]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] rr; logic rm, ok; int base, mh;
    int exp_order[6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    base = g_addr.size(); mh = multi_hot;
    chan_en = 1'b1; lat = 2; fixed_data = 1'b0;
    for (int i = 0; i < NREQ; i++) rd_addr[i*AW +: AW] = AW'(32'h1000 * (i + 1));
    rd_req = 3'b111;
    for (int n = 0; n < 6; n++) begin
      wait_pulse(50, rr, rm, ok);
      if (n == 5) rd_req = '0;
      checks++; if (ok !== 1'b1 || rr !== (3'b001 << exp_order[n])) begin
        failures++; $display("FAIL rr_order n=%0d got=%b exp=%b", n, rr, 3'b001 << exp_order[n]);
      end
      checks++; if (rd_data !== (16'(16'h1000 * (exp_order[n] + 1)) ^ 16'h5A5A)) begin
        failures++; $display("FAIL rr_data n=%0d got=%h exp=%h", n, rd_data, 16'(16'h1000 * (exp_order[n] + 1)) ^ 16'h5A5A);
      end
    end
    cycles(5);
    checks++; if (g_addr.size() - base !== 6) begin failures++; $display("FAIL rr_grants got=%0d exp=6", g_addr.size() - base); end
    for (int n = base + 1; n < g_gap.size() && n < base + 6; n++) begin
      checks++; if (g_gap[n] < 1) begin failures++; $display("FAIL rr_gap n=%0d got=%0d exp>=1", n - base, g_gap[n]); end
    end
    checks++; if (multi_hot !== mh) begin failures++; $display("FAIL rr_onehot got=%0d exp=%0d", multi_hot, mh); end
  endtask

  task automatic test_rom();
    logic [NREQ-1:0] rr; logic rm, ok; int base, rp;
    base = g_addr.size(); rp = rd_pulses;
    chan_en = 1'b1; lat = 2;
    rom_mode = 1'b1; rom_addr = 25'h20; rom_din = 16'h1234; rom_be = 2'b01; rom_req = 1'b1;
    rd_req = 3'b111;
    wait_pulse(50, rr, rm, ok);
    rom_req = 1'b0;
    checks++; if (ok !== 1'b1 || rm !== 1'b1 || rr !== '0) begin failures++; $display("FAIL rom_pulse got=%b/%b exp=rom 1 rd 000", rm, rr); end
    cycles(8);
    checks++; if (g_addr.size() - base !== 1) begin failures++; $display("FAIL rom_grants got=%0d exp=1", g_addr.size() - base); end
    if (g_addr.size() > base) begin
      checks++; if (g_rnw[base] !== 1'b0 || g_be[base] !== 2'b01) begin failures++; $display("FAIL rom_ctl got=%b/%b exp=0/01", g_rnw[base], g_be[base]); end
      checks++; if (g_addr[base] !== 25'h20 || g_din[base] !== 16'h1234) begin failures++; $display("FAIL rom_bus got=%h/%h exp=20/1234", g_addr[base], g_din[base]); end
    end
    checks++; if (rd_pulses !== rp) begin failures++; $display("FAIL rom_no_rd got=%0d exp=%0d", rd_pulses - rp, 0); end
    rd_req = '0; rom_mode = 1'b0;
    cycles(2);
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] rr; logic rm, ok; int base, hb, rp, n;
    do_reset();
    base = g_addr.size(); hb = g_hi.size(); rp = rd_pulses;
    chan_en = 1'b0; fixed_data = 1'b0;
    rd_addr[0 +: AW] = 25'h0ABC;
    rd_req = 3'b001;
    cycles(21);
    lat = 0; chan_en = 1'b1;
    wait_pulse(40, rr, rm, ok);
    rd_req = '0;
    checks++; if (ok !== 1'b1 || rr !== 3'b001) begin failures++; $display("FAIL tmo_rd_rdy got=%b exp=001", rr); end
    checks++; if (rd_data !== (16'h0ABC ^ 16'h5A5A)) begin failures++; $display("FAIL tmo_data got=%h exp=%h", rd_data, 16'h0ABC ^ 16'h5A5A); end
    cycles(5);
    checks++; if (tmo_err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", tmo_err); end
    n = g_addr.size() - base;
    checks++; if (n < 3) begin failures++; $display("FAIL tmo_reissues got=%0d exp>=3", n); end
    for (int i = base; i < g_addr.size(); i++) begin
      checks++; if (g_addr[i] !== 25'h0ABC) begin failures++; $display("FAIL tmo_addr i=%0d got=%h exp=0abc", i - base, g_addr[i]); end
    end
    for (int i = base + 1; i < g_gap.size(); i++) begin
      checks++; if (g_gap[i] !== 1) begin failures++; $display("FAIL tmo_gap i=%0d got=%0d exp=1", i - base, g_gap[i]); end
    end
    for (int i = hb; i < g_hi.size() - 1; i++) begin
      checks++; if (g_hi[i] !== TMO + 1) begin failures++; $display("FAIL tmo_hi i=%0d got=%0d exp=%0d", i - hb, g_hi[i], TMO + 1); end
    end
    checks++; if (rd_pulses - rp !== 1) begin failures++; $display("FAIL tmo_pulses got=%0d exp=1", rd_pulses - rp); end
  endtask

  task automatic test_reset_mid();
    int rp, w;
    rp = rd_pulses;
    chan_en = 1'b0;
    rd_addr[2*AW +: AW] = 25'h777;
    rd_req = 3'b100;
    w = 0;
    while (!sdr_req && w < 20) begin @(negedge clk); w++; end
    checks++; if (sdr_req !== 1'b1) begin failures++; $display("FAIL mid_grant got=%b exp=1", sdr_req); end
    cycles(2);
    reset = 1'b1; rd_req = '0;
    cycles(1);
    checks++; if (sdr_req !== 1'b0 || sdr_rnw !== 1'b1 || sdr_be !== 2'b11) begin
      failures++; $display("FAIL mid_ctl got=%b/%b/%b exp=0/1/11", sdr_req, sdr_rnw, sdr_be);
    end
    checks++; if (sdr_addr !== '0 || rd_data !== '0 || tmo_err !== 1'b0) begin
      failures++; $display("FAIL mid_regs got=%h/%h/%b exp=0/0/0", sdr_addr, rd_data, tmo_err);
    end
    reset = 1'b0;
    man_rdy = 1'b1;
    cycles(1);
    man_rdy = 1'b0;
    cycles(5);
    checks++; if (rd_pulses !== rp || sdr_req !== 1'b0) begin failures++; $display("FAIL mid_late_rdy got=%0d/%b exp=0/0", rd_pulses - rp, sdr_req); end
  endtask

  task automatic test_rom_switch();
    logic [NREQ-1:0] rr; logic rm, ok; int base, rp, w;
    base = g_addr.size();
    chan_en = 1'b1; lat = 3; fixed_data = 1'b0;
    rd_addr[0 +: AW] = 25'h0333;
    rd_addr[1*AW +: AW] = 25'h0444;
    rd_req = 3'b001;
    w = 0;
    while (!sdr_req && w < 20) begin @(negedge clk); w++; end
    rom_mode = 1'b1; rom_req = 1'b1; rom_addr = 25'h40; rom_din = 16'hCAFE; rom_be = 2'b11;
    rd_req = 3'b011;
    wait_pulse(50, rr, rm, ok);
    checks++; if (ok !== 1'b1 || rr !== 3'b001) begin failures++; $display("FAIL sw_read got=%b exp=001", rr); end
    checks++; if (rd_data !== (16'h0333 ^ 16'h5A5A)) begin failures++; $display("FAIL sw_data got=%h exp=%h", rd_data, 16'h0333 ^ 16'h5A5A); end
    wait_pulse(50, rr, rm, ok);
    rom_req = 1'b0;
    checks++; if (ok !== 1'b1 || rm !== 1'b1 || rr !== '0) begin failures++; $display("FAIL sw_rom got=%b/%b exp=1/000", rm, rr); end
    if (g_addr.size() > base + 1) begin
      checks++; if (g_rnw[base + 1] !== 1'b0 || g_addr[base + 1] !== 25'h40) begin
        failures++; $display("FAIL sw_rom_bus got=%b/%h exp=0/40", g_rnw[base + 1], g_addr[base + 1]);
      end
    end
    rp = rd_pulses;
    cycles(10);
    checks++; if (g_addr.size() - base !== 2 || rd_pulses !== rp) begin
      failures++; $display("FAIL sw_starve got=%0d/%0d exp=2/0", g_addr.size() - base, rd_pulses - rp);
    end
    rom_mode = 1'b0;
    wait_pulse(50, rr, rm, ok);
    rd_req = '0;
    checks++; if (ok !== 1'b1 || rr !== 3'b010) begin failures++; $display("FAIL sw_resume got=%b exp=010", rr); end
    checks++; if (rd_data !== (16'h0444 ^ 16'h5A5A)) begin failures++; $display("FAIL sw_resume_data got=%h exp=%h", rd_data, 16'h0444 ^ 16'h5A5A); end
    cycles(3);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rom();
    test_timeout();
    test_reset_mid();
    test_rom_switch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
